// File: rtl/pipeline_hazard_controller_if.sv
// Handshake bundle between the hazard controller and the pipeline datapath.
// The datapath side is the master; the controller is the slave.
interface pipeline_hazard_controller_if #(
    parameter int STALL_CNT_W = 16
);
    logic [4:0]             IF_ID_Rs;
    logic [4:0]             IF_ID_Rt;
    logic                   Uses_Rt;
    logic                   ID_EX_MemRead;
    logic [4:0]             ID_EX_Rt;
    logic                   Branch_Taken;
    logic                   Jump;
    logic                   Md_Start;
    logic                   Stall_Clear;
    logic                   PC_Enable;
    logic                   IF_ID_Enable;
    logic                   Flush_Branch;
    logic                   Flush_Jump;
    logic                   ID_EX_Bubble;
    logic                   Busy;
    logic [STALL_CNT_W-1:0] Stall_Count;

    modport master (
        output IF_ID_Rs, IF_ID_Rt, Uses_Rt, ID_EX_MemRead, ID_EX_Rt,
               Branch_Taken, Jump, Md_Start, Stall_Clear,
        input  PC_Enable, IF_ID_Enable, Flush_Branch, Flush_Jump,
               ID_EX_Bubble, Busy, Stall_Count
    );

    modport slave (
        input  IF_ID_Rs, IF_ID_Rt, Uses_Rt, ID_EX_MemRead, ID_EX_Rt,
               Branch_Taken, Jump, Md_Start, Stall_Clear,
        output PC_Enable, IF_ID_Enable, Flush_Branch, Flush_Jump,
               ID_EX_Bubble, Busy, Stall_Count
    );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use stalls, branch and
// jump flushes, multi-cycle mul/div stalls and a saturating stall-cycle counter.
module pipeline_hazard_controller #(
    parameter int MD_LATENCY          = 4,
    parameter int BRANCH_FLUSH_CYCLES = 1,
    parameter int STALL_CNT_W         = 16
) (
    input logic                         clk,
    input logic                         rst,
    pipeline_hazard_controller_if.slave bus
);
    typedef enum logic [1:0] {
        RUN,
        FLUSH_HOLD,
        MD_BUSY
    } state_t;

    localparam logic [7:0] LP_BR_LOAD = 8'(BRANCH_FLUSH_CYCLES - 2);
    localparam logic [7:0] LP_MD_LOAD = 8'(MD_LATENCY - 1);

    state_t                 r_state;
    state_t                 w_next_state;
    logic [7:0]             r_cnt;
    logic [7:0]             w_next_cnt;
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    logic w_load_use;
    logic w_pc_enable;
    logic w_if_id_enable;
    logic w_flush_branch;
    logic w_flush_jump;
    logic w_bubble;
    logic w_busy;

    assign w_load_use = bus.ID_EX_MemRead && (bus.ID_EX_Rt != '0) &&
                        ((bus.ID_EX_Rt == bus.IF_ID_Rs) ||
                         (bus.Uses_Rt && (bus.ID_EX_Rt == bus.IF_ID_Rt)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    always_comb begin
        w_next_state   = r_state;
        w_next_cnt     = r_cnt;
        w_pc_enable    = 1'b1;
        w_if_id_enable = 1'b1;
        w_flush_branch = 1'b0;
        w_flush_jump   = 1'b0;
        w_bubble       = 1'b0;
        w_busy         = 1'b0;

        case (r_state)
            RUN: begin
                if (bus.Branch_Taken) begin
                    w_flush_branch = 1'b1;
                    w_bubble       = 1'b1;
                    if (BRANCH_FLUSH_CYCLES > 1) begin
                        w_next_state = FLUSH_HOLD;
                        w_next_cnt   = LP_BR_LOAD;
                    end
                end else if (bus.Jump) begin
                    w_flush_jump = 1'b1;
                end else if (w_load_use) begin
                    w_pc_enable    = 1'b0;
                    w_if_id_enable = 1'b0;
                    w_bubble       = 1'b1;
                end else if (bus.Md_Start) begin
                    w_next_state = MD_BUSY;
                    w_next_cnt   = LP_MD_LOAD;
                end
            end
            FLUSH_HOLD: begin
                w_flush_branch = 1'b1;
                w_bubble       = 1'b1;
                w_busy         = 1'b1;
                if (r_cnt == '0) w_next_state = RUN;
                else             w_next_cnt   = r_cnt - 8'd1;
            end
            MD_BUSY: begin
                w_pc_enable    = 1'b0;
                w_if_id_enable = 1'b0;
                w_bubble       = 1'b1;
                w_busy         = 1'b1;
                if (r_cnt == '0) w_next_state = RUN;
                else             w_next_cnt   = r_cnt - 8'd1;
            end
            default: begin
                w_next_state = RUN;
                w_next_cnt   = '0;
            end
        endcase

        // Reset overrides outputs combinationally so they change without waiting for an edge.
        if (rst) begin
            w_pc_enable    = 1'b0;
            w_if_id_enable = 1'b0;
            w_flush_branch = 1'b0;
            w_flush_jump   = 1'b0;
            w_bubble       = 1'b1;
            w_busy         = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_stall_cnt <= '0;
        else if (bus.Stall_Clear)
            r_stall_cnt <= '0;
        else if (!w_pc_enable && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + 1'b1;
    end

    assign bus.PC_Enable    = w_pc_enable;
    assign bus.IF_ID_Enable = w_if_id_enable;
    assign bus.Flush_Branch = w_flush_branch;
    assign bus.Flush_Jump   = w_flush_jump;
    assign bus.ID_EX_Bubble = w_bubble;
    assign bus.Busy         = w_busy;
    assign bus.Stall_Count  = r_stall_cnt;
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller: three builds share one stimulus
// (a: flush 1 / md 4 / cnt 16, b: flush 3 / md 1 / cnt 16, c: flush 1 / md 4 / cnt 4).
module tb_pipeline_hazard_controller;
    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [4:0] r_rs, r_rt, r_ex_rt;
    logic       r_uses_rt, r_memread, r_branch, r_jump, r_md_start, r_clear;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipeline_hazard_controller_if #(.STALL_CNT_W(16)) if_a ();
    pipeline_hazard_controller_if #(.STALL_CNT_W(16)) if_b ();
    pipeline_hazard_controller_if #(.STALL_CNT_W(4))  if_c ();

    pipeline_hazard_controller #(.MD_LATENCY(4), .BRANCH_FLUSH_CYCLES(1), .STALL_CNT_W(16))
        dut_a (.clk(clk), .rst(rst), .bus(if_a));
    pipeline_hazard_controller #(.MD_LATENCY(1), .BRANCH_FLUSH_CYCLES(3), .STALL_CNT_W(16))
        dut_b (.clk(clk), .rst(rst), .bus(if_b));
    pipeline_hazard_controller #(.MD_LATENCY(4), .BRANCH_FLUSH_CYCLES(1), .STALL_CNT_W(4))
        dut_c (.clk(clk), .rst(rst), .bus(if_c));

    assign if_a.IF_ID_Rs = r_rs;      assign if_b.IF_ID_Rs = r_rs;      assign if_c.IF_ID_Rs = r_rs;
    assign if_a.IF_ID_Rt = r_rt;      assign if_b.IF_ID_Rt = r_rt;      assign if_c.IF_ID_Rt = r_rt;
    assign if_a.Uses_Rt = r_uses_rt;  assign if_b.Uses_Rt = r_uses_rt;  assign if_c.Uses_Rt = r_uses_rt;
    assign if_a.ID_EX_MemRead = r_memread;
    assign if_b.ID_EX_MemRead = r_memread;
    assign if_c.ID_EX_MemRead = r_memread;
    assign if_a.ID_EX_Rt = r_ex_rt;   assign if_b.ID_EX_Rt = r_ex_rt;   assign if_c.ID_EX_Rt = r_ex_rt;
    assign if_a.Branch_Taken = r_branch;
    assign if_b.Branch_Taken = r_branch;
    assign if_c.Branch_Taken = r_branch;
    assign if_a.Jump = r_jump;        assign if_b.Jump = r_jump;        assign if_c.Jump = r_jump;
    assign if_a.Md_Start = r_md_start;
    assign if_b.Md_Start = r_md_start;
    assign if_c.Md_Start = r_md_start;
    assign if_a.Stall_Clear = r_clear;
    assign if_b.Stall_Clear = r_clear;
    assign if_c.Stall_Clear = r_clear;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        r_rs = '0; r_rt = '0; r_ex_rt = '0;
        r_uses_rt = 1'b0; r_memread = 1'b0; r_branch = 1'b0;
        r_jump = 1'b0; r_md_start = 1'b0; r_clear = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_load_use();
        r_memread = 1'b1; r_ex_rt = 5'd5; r_rs = 5'd5;
    endtask

    initial begin
        idle();
        #2;
        chk("rst_pc_en",   32'(if_a.PC_Enable),    32'd0);
        chk("rst_ifid_en", 32'(if_a.IF_ID_Enable), 32'd0);
        chk("rst_bubble",  32'(if_a.ID_EX_Bubble), 32'd1);
        chk("rst_busy",    32'(if_a.Busy),         32'd0);
        chk("rst_fb",      32'(if_a.Flush_Branch), 32'd0);
        chk("rst_cnt",     32'(if_a.Stall_Count),  32'd0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("run_pc_en", 32'(if_a.PC_Enable),    32'd1);
        chk("run_bub",   32'(if_a.ID_EX_Bubble), 32'd0);

        // Load-use on rs
        step();
        set_load_use();
        @(negedge clk);
        chk("lu_pc_en",   32'(if_a.PC_Enable),    32'd0);
        chk("lu_ifid_en", 32'(if_a.IF_ID_Enable), 32'd0);
        chk("lu_bubble",  32'(if_a.ID_EX_Bubble), 32'd1);
        step();
        chk("lu_cnt1", 32'(if_a.Stall_Count), 32'd1);
        // Load to r0 never stalls
        r_ex_rt = 5'd0; r_rs = 5'd0;
        @(negedge clk);
        chk("lu_r0_pc_en", 32'(if_a.PC_Enable), 32'd1);
        chk("lu_r0_bub",   32'(if_a.ID_EX_Bubble), 32'd0);
        step();
        chk("lu_r0_cnt", 32'(if_a.Stall_Count), 32'd1);
        // rt match only counts when Uses_Rt
        r_ex_rt = 5'd7; r_rt = 5'd7; r_rs = 5'd3; r_uses_rt = 1'b0;
        @(negedge clk);
        chk("lu_rt_nouse", 32'(if_a.PC_Enable), 32'd1);
        step();
        r_uses_rt = 1'b1;
        @(negedge clk);
        chk("lu_rt_use", 32'(if_a.PC_Enable), 32'd0);
        step();
        chk("lu_cnt2", 32'(if_a.Stall_Count), 32'd2);
        idle();

        // Branch beats jump and load-use
        r_branch = 1'b1; r_jump = 1'b1; set_load_use();
        @(negedge clk);
        chk("br_fb_a",   32'(if_a.Flush_Branch), 32'd1);
        chk("br_bub_a",  32'(if_a.ID_EX_Bubble), 32'd1);
        chk("br_pc_a",   32'(if_a.PC_Enable),    32'd1);
        chk("br_fj_a",   32'(if_a.Flush_Jump),   32'd0);
        chk("br_fb_b1",  32'(if_b.Flush_Branch), 32'd1);
        chk("br_busy_b1", 32'(if_b.Busy),        32'd0);
        step();
        idle();
        @(negedge clk);
        chk("br_fb_a2",   32'(if_a.Flush_Branch), 32'd0);
        chk("br_fb_b2",   32'(if_b.Flush_Branch), 32'd1);
        chk("br_busy_b2", 32'(if_b.Busy),         32'd1);
        chk("br_pc_b2",   32'(if_b.PC_Enable),    32'd1);
        step();
        @(negedge clk);
        chk("br_fb_b3",   32'(if_b.Flush_Branch), 32'd1);
        chk("br_busy_b3", 32'(if_b.Busy),         32'd1);
        step();
        @(negedge clk);
        chk("br_fb_b4",   32'(if_b.Flush_Branch), 32'd0);
        chk("br_busy_b4", 32'(if_b.Busy),         32'd0);
        chk("br_cnt_a",   32'(if_a.Stall_Count),  32'd2);

        // Jump alone
        r_jump = 1'b1;
        @(negedge clk);
        chk("j_fj", 32'(if_a.Flush_Jump),   32'd1);
        chk("j_pc", 32'(if_a.PC_Enable),    32'd1);
        chk("j_fb", 32'(if_a.Flush_Branch), 32'd0);
        step();
        r_jump = 1'b0;
        @(negedge clk);
        chk("j_fj_off", 32'(if_a.Flush_Jump), 32'd0);
        chk("j_cnt",    32'(if_a.Stall_Count), 32'd2);

        // Clear, then mul/div with a jump waiting behind it
        r_clear = 1'b1;
        step();
        r_clear = 1'b0;
        chk("clr_cnt", 32'(if_a.Stall_Count), 32'd0);
        r_md_start = 1'b1;
        @(negedge clk);
        chk("md0_pc",   32'(if_a.PC_Enable), 32'd1);
        chk("md0_busy", 32'(if_a.Busy),      32'd0);
        step();
        r_md_start = 1'b0; r_jump = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk($sformatf("md%0d_pc", i),   32'(if_a.PC_Enable),    32'd0);
            chk($sformatf("md%0d_busy", i), 32'(if_a.Busy),         32'd1);
            chk($sformatf("md%0d_bub", i),  32'(if_a.ID_EX_Bubble), 32'd1);
            chk($sformatf("md%0d_fj", i),   32'(if_a.Flush_Jump),   32'd0);
            step();
        end
        @(negedge clk);
        chk("md5_pc",   32'(if_a.PC_Enable),   32'd1);
        chk("md5_busy", 32'(if_a.Busy),        32'd0);
        chk("md5_fj",   32'(if_a.Flush_Jump),  32'd1);
        chk("md5_cnt",  32'(if_a.Stall_Count), 32'd4);
        step();
        idle();

        // Asynchronous reset in the middle of MD_BUSY
        r_md_start = 1'b1;
        step();
        r_md_start = 1'b0;
        step();
        #2;
        rst = 1'b1;
        #1;
        chk("ar_pc",   32'(if_a.PC_Enable),    32'd0);
        chk("ar_ifid", 32'(if_a.IF_ID_Enable), 32'd0);
        chk("ar_bub",  32'(if_a.ID_EX_Bubble), 32'd1);
        chk("ar_busy", 32'(if_a.Busy),         32'd0);
        chk("ar_cnt",  32'(if_a.Stall_Count),  32'd0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("ar_run_pc",   32'(if_a.PC_Enable),   32'd1);
        chk("ar_run_busy", 32'(if_a.Busy),        32'd0);
        chk("ar_run_cnt",  32'(if_a.Stall_Count), 32'd0);
        step();

        // Saturation of the 4-bit counter, then clear racing a stall
        set_load_use();
        for (int i = 0; i < 20; i++) step();
        chk("sat_c", 32'(if_c.Stall_Count), 32'd15);
        chk("sat_a", 32'(if_a.Stall_Count), 32'd20);
        r_clear = 1'b1;
        step();
        chk("clr_stall_c", 32'(if_c.Stall_Count), 32'd0);
        chk("clr_stall_a", 32'(if_a.Stall_Count), 32'd0);
        r_clear = 1'b0;
        step();
        chk("post_clr_c", 32'(if_c.Stall_Count), 32'd1);
        idle();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
